// File: rtl/axi_lcd_tou_regs_slave.sv
// axi_lcd_tou_regs_slave
//   AXI4-Lite responder for the LCD/touch driver control registers. It holds
//   NUM_REGS 32-bit read/write words at byte offsets 0x00, 0x04, ... Each
//   register reads back whatever was last written to it. Any access to a word
//   index at or above NUM_REGS is answered with SLVERR.
//
// Ports
//   ACLK, ARESET        clock and synchronous active-high reset
//   S_AXI_AW*/W*/B*     write address, write data and write response channels
//   S_AXI_AR*/R*        read address and read data channels
//   REG_OUT             all register contents; register k is at [32k+31:32k]
//   REG_WR_PULSE        one-cycle strobe per register, high in the cycle
//                       after that register is written
//
// Write path
//   AW and W are each captured into a 1-deep holding register. A commit fires
//   once both holds are full and no B response is outstanding.
//
// Read path
//   A single registered R beat. It is independent of the write path, so a read
//   that is accepted on the same edge as a commit returns the pre-write value.

// One register word with byte enables and a write strobe.
module axi_lcd_tou_reg_word #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [DW/8-1:0] strb,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   q,
  output logic            wr_pulse
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      wr_pulse <= 1'b0;
    end else begin
      // The strobe fires for every mapped write, even when WSTRB is all zero.
      wr_pulse <= we;
      if (we) begin
        for (int b = 0; b < DW/8; b++)
          if (strb[b]) q[8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end
endmodule

module axi_lcd_tou_regs_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 4
) (
  input  logic                                  ACLK,
  input  logic                                  ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_AWADDR,
  input  logic [2:0]                            S_AXI_AWPROT,
  input  logic                                  S_AXI_AWVALID,
  output logic                                  S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
  input  logic                                  S_AXI_WVALID,
  output logic                                  S_AXI_WREADY,
  output logic [1:0]                            S_AXI_BRESP,
  output logic                                  S_AXI_BVALID,
  input  logic                                  S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_ARADDR,
  input  logic [2:0]                            S_AXI_ARPROT,
  input  logic                                  S_AXI_ARVALID,
  output logic                                  S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_RDATA,
  output logic [1:0]                            S_AXI_RRESP,
  output logic                                  S_AXI_RVALID,
  input  logic                                  S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] REG_OUT,
  output logic [NUM_REGS-1:0]                   REG_WR_PULSE
);
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int IDX_W = AW - 2;
  localparam logic [IDX_W:0] REG_LIMIT = (IDX_W+1)'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Protection bits and the byte offset within a word play no part in decode.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  logic                  aw_full, w_full;
  logic [IDX_W-1:0]      aw_idx;
  logic [DW-1:0]         w_data;
  logic [DW/8-1:0]       w_strb;
  logic                  bvalid, rvalid;
  logic [1:0]            bresp, rresp;
  logic [DW-1:0]         rdata;
  logic [NUM_REGS-1:0]   reg_we;
  logic [NUM_REGS-1:0][DW-1:0] reg_q;
  logic                  commit, aw_mapped, rd_mapped;
  logic [IDX_W-1:0]      rd_idx;
  logic [DW-1:0]         rd_word;

  assign commit    = aw_full && w_full && !bvalid;
  assign aw_mapped = {1'b0, aw_idx} < REG_LIMIT;
  assign rd_idx    = S_AXI_ARADDR[AW-1:2];
  assign rd_mapped = {1'b0, rd_idx} < REG_LIMIT;

  // An unmapped index matches no entry, so the mux yields zero for it.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (rd_idx == IDX_W'(k)) rd_word = reg_q[k];
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    assign reg_we[k] = commit && aw_mapped && (aw_idx == IDX_W'(k));
    axi_lcd_tou_reg_word #(.DW(DW)) u_word (
      .clk      (ACLK),
      .rst      (ARESET),
      .we       (reg_we[k]),
      .strb     (w_strb),
      .wdata    (w_data),
      .q        (reg_q[k]),
      .wr_pulse (REG_WR_PULSE[k])
    );
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full <= 1'b0;
      aw_idx  <= '0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      if (S_AXI_AWVALID && !aw_full) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[AW-1:2];
      end
      if (S_AXI_WVALID && !w_full) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (bvalid && S_AXI_BREADY) bvalid <= 1'b0;
      // A commit needs both holds to be full, so it never coincides with a
      // new capture. It also needs bvalid low, so it never collides with the
      // B retire above.
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= aw_mapped ? RESP_OKAY : RESP_SLVERR;
      end
      if (S_AXI_ARVALID && !rvalid) begin
        rvalid <= 1'b1;
        rdata  <= rd_word;
        rresp  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid && S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = !aw_full;
  assign S_AXI_WREADY  = !w_full;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_ARREADY = !rvalid;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;
  assign REG_OUT       = reg_q;
endmodule
